// File: rtl/mmio_timer_if.sv
// Bus bundle between the core data port and the memory-mapped timer.
// The master drives the store strobe/address/data; the timer answers with read data, hit and irq.
interface mmio_timer_if;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        hit;
  logic        irq;

  modport master (
    output we,
    output a,
    output wd,
    input  rd,
    input  hit,
    input  irq
  );

  modport slave (
    input  we,
    input  a,
    input  wd,
    output rd,
    output hit,
    output irq
  );
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled up-counter with compare match, sticky match flag,
// optional auto-reload and a level interrupt, sitting beside dmem on the core data port.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter int          CNT_WIDTH   = 32,
  parameter int          PRESC_WIDTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  mmio_timer_if.slave  bus
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PRESC  = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_CMP    = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = PRESC_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);

  logic                   en_q, en_d;
  logic                   auto_q, auto_d;
  logic                   irq_en_q, irq_en_d;
  logic                   match_q, match_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic [PRESC_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic [CNT_WIDTH-1:0]   cmp_q, cmp_d;

  logic       hit;
  logic       wr;
  logic [2:0] off;
  logic       tick;
  logic       count_eq;
  logic       match_set;
  logic [31:0] rd_mux;

  // Byte lanes and the upper write-data bits beyond the register widths carry no state.
  logic unused_bits;
  assign unused_bits = ^{bus.a[1:0], bus.wd};

  assign hit       = (bus.a[31:5] == BASE_ADDR[31:5]);
  assign off       = bus.a[4:2];
  assign wr        = bus.we & hit;
  assign tick      = en_q && (pcnt_q == presc_q);
  assign count_eq  = (count_q == cmp_q);
  assign match_set = tick && count_eq;

  always_comb begin
    en_d     = en_q;
    auto_d   = auto_q;
    irq_en_d = irq_en_q;
    match_d  = match_q;
    presc_d  = presc_q;
    pcnt_d   = pcnt_q;
    count_d  = count_q;
    cmp_d    = cmp_q;

    if (en_q) begin
      pcnt_d = tick ? '0 : (pcnt_q + PRESC_ONE);
    end

    // The tick uses the registered EN/AUTO_RELOAD, so a CTRL write on this edge
    // neither starts nor cancels the current tick.
    if (tick) begin
      count_d = (count_eq && auto_q) ? '0 : (count_q + CNT_ONE);
    end

    if (wr) begin
      unique case (off)
        OFF_CTRL: begin
          en_d     = bus.wd[0];
          auto_d   = bus.wd[1];
          irq_en_d = bus.wd[2];
        end
        OFF_PRESC: begin
          presc_d = bus.wd[PRESC_WIDTH-1:0];
          pcnt_d  = '0;
        end
        OFF_COUNT: begin
          count_d = bus.wd[CNT_WIDTH-1:0];
          pcnt_d  = '0;
        end
        OFF_CMP: begin
          cmp_d = bus.wd[CNT_WIDTH-1:0];
        end
        OFF_STATUS: begin
          if (bus.wd[0]) begin
            match_d = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end

    // A hardware match beats a same-edge software clear.
    if (match_set) begin
      match_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      irq_en_q <= 1'b0;
      match_q  <= 1'b0;
      presc_q  <= '0;
      pcnt_q   <= '0;
      count_q  <= '0;
      cmp_q    <= '0;
    end else begin
      en_q     <= en_d;
      auto_q   <= auto_d;
      irq_en_q <= irq_en_d;
      match_q  <= match_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      count_q  <= count_d;
      cmp_q    <= cmp_d;
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    if (hit) begin
      unique case (off)
        OFF_CTRL:   rd_mux = {29'h0, irq_en_q, auto_q, en_q};
        OFF_PRESC:  rd_mux = 32'(presc_q);
        OFF_COUNT:  rd_mux = 32'(count_q);
        OFF_CMP:    rd_mux = 32'(cmp_q);
        OFF_STATUS: rd_mux = {31'h0, match_q};
        default:    rd_mux = 32'h0;
      endcase
    end
  end

  assign bus.rd  = rd_mux;
  assign bus.hit = hit;
  assign bus.irq = irq_en_q & match_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Randomised and directed stimulus for mmio_timer, checked against a register-level
// model of the timer's documented behaviour.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #50 clk = ~clk;

  mmio_timer_if bus ();

  mmio_timer #(
    .BASE_ADDR   (BASE),
    .CNT_WIDTH   (32),
    .PRESC_WIDTH (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Programmer-visible state of the timer as the model sees it.
  logic [31:0] m_ctrl, m_presc, m_count, m_cmp;
  logic        m_match;
  int unsigned m_pcnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl  = 0;
    m_presc = 0;
    m_count = 0;
    m_cmp   = 0;
    m_match = 0;
    m_pcnt  = 0;
  endtask

  // Apply one clock edge's worth of behaviour to the model.
  task automatic model_edge(input logic w, input logic [31:0] addr, input logic [31:0] data,
                            input logic rst_n);
    logic       in_win, tick, set_m;
    logic [2:0] reg_idx;
    if (!rst_n) begin
      model_reset();
      return;
    end
    in_win  = (addr[31:5] == BASE[31:5]);
    reg_idx = addr[4:2];
    tick    = m_ctrl[0] && (m_pcnt == m_presc);
    set_m   = tick && (m_count == m_cmp);
    if (m_ctrl[0]) m_pcnt = tick ? 0 : (m_pcnt + 1) % 65536;
    if (tick) m_count = (set_m && m_ctrl[1]) ? 32'h0 : m_count + 32'h1;
    if (w && in_win) begin
      case (reg_idx)
        3'd0: m_ctrl = data & 32'h7;
        3'd1: begin m_presc = data & 32'hFFFF; m_pcnt = 0; end
        3'd2: begin m_count = data; m_pcnt = 0; end
        3'd3: m_cmp = data;
        3'd4: if (data[0]) m_match = 1'b0;
        default: ;
      endcase
    end
    if (set_m) m_match = 1'b1;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    if (addr[31:5] != BASE[31:5]) return 32'h0;
    case (addr[4:2])
      3'd0:    return m_ctrl;
      3'd1:    return m_presc;
      3'd2:    return m_count;
      3'd3:    return m_cmp;
      3'd4:    return {31'h0, m_match};
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge with the given bus/reset values; one line per transaction.
  task automatic edge_op(input logic w, input logic [31:0] addr, input logic [31:0] data,
                         input logic rst_n);
    @(negedge clk);
    bus.we = w;
    bus.a  = addr;
    bus.wd = data;
    reset  = rst_n;
    @(posedge clk);
    model_edge(w, addr, data, rst_n);
    #1;
    bus.we = 1'b0;
    $display("txn rst_n=%0b we=%0b a=%h wd=%h", rst_n, w, addr, data);
  endtask

  task automatic wr(input int idx, input logic [31:0] data);
    edge_op(1'b1, BASE + 32'(idx * 4), data, 1'b1);
  endtask

  task automatic idle();
    edge_op(1'b0, BASE, 32'h0, 1'b1);
  endtask

  // Read every window offset plus one address outside the window, and irq.
  task automatic check_all(input string tag);
    logic [31:0] addr;
    for (int i = 0; i < 8; i++) begin
      addr = BASE + 32'(i * 4) + 32'($urandom_range(0, 3));
      bus.a = addr;
      #1;
      check_val($sformatf("%s_rd%0d", tag, i), bus.rd, model_read(addr));
      check_val($sformatf("%s_hit%0d", tag, i), {31'h0, bus.hit}, 32'h1);
    end
    addr = (BASE + 32'h20) + 32'($urandom_range(0, 31)) * 32'h20;
    bus.a = addr;
    #1;
    check_val($sformatf("%s_hit_out", tag), {31'h0, bus.hit}, 32'h0);
    check_val($sformatf("%s_rd_out", tag), bus.rd, 32'h0);
    check_val($sformatf("%s_irq", tag), {31'h0, bus.irq}, {31'h0, m_ctrl[2] & m_match});
  endtask

  initial begin
    bus.we = 1'b0;
    bus.a  = 32'h0;
    bus.wd = 32'h0;
    model_reset();
    edge_op(1'b0, BASE, 32'h0, 1'b0);
    check_all("por");

    // Random writes then a reset edge that also carries a write.
    reset = 1'b1;
    for (int i = 0; i < 5; i++) wr(i, $urandom);
    check_all("pre_rst");
    edge_op(1'b1, BASE + 32'h8, 32'h1234_5678, 1'b0);
    check_all("rst");

    // Single-cycle prescaler with compare and interrupt.
    wr(1, 32'h0); wr(3, 32'h3); wr(2, 32'h0); wr(0, 32'h5);
    check_all("cnt_en");
    for (int i = 0; i < 6; i++) begin idle(); check_all("cnt"); end

    // Divide-by-3 prescaler; rewriting PRESC restarts the phase.
    wr(0, 32'h0); wr(4, 32'h1); wr(1, 32'h2); wr(2, 32'h0); wr(0, 32'h1);
    for (int i = 0; i < 7; i++) begin idle(); check_all("presc"); end
    wr(1, 32'h2);
    for (int i = 0; i < 4; i++) begin idle(); check_all("presc_rs"); end

    // Auto-reload with IRQ disabled.
    wr(0, 32'h0); wr(1, 32'h0); wr(2, 32'h0); wr(3, 32'h2); wr(0, 32'h3);
    for (int i = 0; i < 7; i++) begin idle(); check_all("reload"); end

    // Clear racing a match, then a plain clear.
    wr(0, 32'h0); wr(4, 32'h1); wr(1, 32'h0); wr(3, 32'h3); wr(2, 32'h2); wr(0, 32'h5);
    idle(); check_all("race_pre");
    wr(4, 32'h1); check_all("race");
    wr(4, 32'h0); check_all("wr0");
    wr(4, 32'h1); check_all("clear");

    // Wrap, out-of-window write, then reset mid-count.
    wr(0, 32'h0); wr(2, 32'hFFFF_FFFF); wr(3, 32'h5); wr(0, 32'h1);
    idle(); check_all("wrap");
    edge_op(1'b1, BASE + 32'h20, 32'hDEAD_BEEF, 1'b1); check_all("oow");
    edge_op(1'b1, BASE + 32'h28, 32'h0000_0007, 1'b1); check_all("oow2");
    idle(); idle(); check_all("pre_mid");
    edge_op(1'b0, BASE, 32'h0, 1'b0); check_all("mid_rst");
    idle(); check_all("post_rst");

    // Randomised traffic biased towards matches and small prescales.
    for (int n = 0; n < 700; n++) begin
      int          r, idx;
      logic [31:0] addr, data;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        edge_op(1'b1, BASE + 32'(4 * $urandom_range(0, 7)), $urandom, 1'b0);
      end else if (r < 50) begin
        edge_op(1'b0, $urandom, $urandom, 1'b1);
      end else begin
        idx  = int'($urandom_range(0, 7));
        addr = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) addr = addr + 32'h20 * 32'($urandom_range(1, 4));
        case (idx)
          0:       data = $urandom | ($urandom_range(0, 3) != 0 ? 32'h1 : 32'h0);
          1:       data = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 3));
          2:       data = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFE : m_cmp - 32'($urandom_range(0, 4));
          3:       data = m_count + 32'($urandom_range(0, 6));
          default: data = $urandom;
        endcase
        edge_op(1'b1, addr, data, 1'b1);
      end
      check_all($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
